delay_block_ring: RTL and testbench
===================================

Name: delay_block_ring

Overview:
- Block-granular ring buffer in one dual-port BRAM, holding SLOTS blocks of BLOCK_SIZE words of WIDTH bits.
- The producer fills the current write slot and commits it. The consumer reads the oldest committed slot and releases it.
- Unlike a fixed-period shift, slot hand-off is elastic. The block tracks occupancy with full/empty flags and an error flag, so producer and consumer stages (NTT, sampler, encode) can run at different block rates.

Parameters:
- WIDTH, 16, data word width in bits.
- BLOCK_SIZE, 512, words per slot; power of two, >= 2.
- SLOTS, 8, number of slots; >= 2, not required to be a power of two.
- Derived: AW = $clog2(BLOCK_SIZE); SW = $clog2(SLOTS); RAM depth = SLOTS*(2**AW).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write word to the current write slot.
- wr_addr  in  AW  word address within the write slot.
- wr_data  in  WIDTH  write data.
- wr_commit  in  1  current write slot is complete; hand it to the consumer.
- wr_ready  out  1  a free write slot exists (count < SLOTS).
- rd_en  in  1  read request from the current read slot.
- rd_addr  in  AW  word address within the read slot.
- rd_data  out  WIDTH  read data, valid when rd_valid = 1.
- rd_valid  out  1  rd_data carries the result of an accepted read.
- rd_release  in  1  consumer is finished with the current read slot.
- rd_ready  out  1  at least one committed slot exists (count > 0).
- wr_slot  out  SW  index of the current write slot.
- rd_slot  out  SW  index of the current read slot.
- count  out  SW+1  number of committed, unreleased slots.
- err  out  1  sticky flag: commit while full or release while empty; cleared only by rst.

Behaviour:
- State registers: wr_slot, rd_slot, count, err, rd_valid, rd_data.
- Reset values: wr_slot=0, rd_slot=0, count=0, err=0, rd_valid=0, rd_data=0. RAM contents are not cleared.
- Combinational flags: wr_ready = (count != SLOTS); rd_ready = (count != 0).
- RAM address formation:
  - Port A address = wr_slot*2**AW + wr_addr.
  - Port B address = rd_slot*2**AW + rd_addr.
  - Port A write enable = wr_en & wr_ready. Writes while full are dropped silently.
- Read latency is 1 cycle:
  - rd_en=1 with rd_ready=1 at edge t gives rd_valid=1 and rd_data = RAM[rd_slot, rd_addr] after edge t+1.
  - rd_en while empty gives rd_valid=0 and rd_data holds its previous value.
- Slot hand-off:
  - Commit is accepted when wr_commit & wr_ready. Then wr_slot advances by 1 and wraps from SLOTS-1 to 0.
  - Release is accepted when rd_release & rd_ready. Then rd_slot advances with the same wrap.
  - count = count + (commit accepted) - (release accepted). Simultaneous accepted commit and release leaves count unchanged and advances both pointers.
  - wr_commit while full: ignored, err<=1. rd_release while empty: ignored, err<=1.
- Same-cycle ordering:
  - A write and a commit in the same cycle write to the pre-commit wr_slot.
  - A read and a release in the same cycle read from the pre-release rd_slot.
  - All flags are evaluated on pre-edge count, so a commit while full is rejected even if a release arrives in the same cycle.
- Read/write collision: with count=0, wr_slot == rd_slot and reads are blocked, so no same-address collision is possible. With count=SLOTS, writes are blocked. The RAM read-during-write mode is therefore irrelevant.
- Reset mid-operation: all pointers and count return to 0 on the next edge. Any in-flight read is discarded (rd_valid=0).

Optional Feature:
- Macro DELAY_BLOCK_RING_FIXED_DELAY_EN.
- When defined, the block adds parameter DELAY (default SLOTS-1, range 1..SLOTS-1) and input shift (1 bit). It then emulates a fixed pipeline delay:
  - shift=1 performs an accepted commit, plus an accepted release once count==DELAY.
  - Result: the read slot trails the write slot by exactly DELAY blocks, and count saturates at DELAY.
  - wr_commit and rd_release are ignored and err never sets.
- When undefined, there is no shift port and the elastic commit/release behaviour above applies.

Test Plan (WIDTH=16, BLOCK_SIZE=8, SLOTS=4):
- Reset then idle -> count=0, wr_ready=1, rd_ready=0, wr_slot=rd_slot=0, err=0, rd_valid=0.
- Write 0x1000+i to addr i (i=0..7), commit; read addr 3 -> count=1, rd_ready=1, wr_slot=1; rd_data=0x1003 with rd_valid one cycle after rd_en.
- Fill 4 slots with data 0xS0A0 (S=slot, A=addr) and commit each -> count=4, wr_ready=0. A 5th wr_en to addr 0 with data 0xFFFF is dropped: after release, slot 0 addr 0 still reads 0x00A0-pattern value 0x0000, not 0xFFFF. A 5th commit sets err=1 and count stays 4.
- At count=2, pulse wr_commit and rd_release in the same cycle -> count stays 2, wr_slot and rd_slot both advance by 1; 3->0 wrap verified after 4 full rounds.
- rd_release at count=0 -> err=1, rd_slot unchanged; rd_en at count=0 -> rd_valid stays 0.
- Assert rst mid-stream at count=3 -> next cycle count=0, both slots 0, err=0, rd_valid=0. Afterwards a write of 0xBEEF to addr 5, a commit and a read of addr 5 return 0xBEEF.

Source files
------------

// File: rtl/delay_block_ring.sv
`default_nettype none
// ============================================================================
// Module   : delay_block_ring
// Purpose  : Block-granular ring buffer in one dual-port RAM with elastic
//            commit/release slot hand-off, occupancy flags and sticky error.
//            Define DELAY_BLOCK_RING_FIXED_DELAY_EN to replace the elastic
//            hand-off with a fixed DELAY-block pipeline driven by 'shift'.
// Revision : 1.0 - initial release
// ============================================================================
module delay_block_ring #(
   parameter int WIDTH      = 16,
   parameter int BLOCK_SIZE = 512,
   parameter int SLOTS      = 8,
`ifdef DELAY_BLOCK_RING_FIXED_DELAY_EN
   parameter int DELAY      = SLOTS - 1,
`endif
   localparam int AW = $clog2(BLOCK_SIZE),
   localparam int SW = $clog2(SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DELAY_BLOCK_RING_FIXED_DELAY_EN
   input  logic             shift,
`endif
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_commit,
   output logic             wr_ready,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_release,
   output logic             rd_ready,
   output logic [SW-1:0]    wr_slot,
   output logic [SW-1:0]    rd_slot,
   output logic [SW:0]      count,
   output logic             err
);

   localparam int            C_DEPTH = SLOTS * (2 ** AW);
   localparam logic [SW:0]   C_SLOTS = (SW + 1)'(SLOTS);
   localparam logic [SW-1:0] C_LAST  = SW'(SLOTS - 1);
`ifdef DELAY_BLOCK_RING_FIXED_DELAY_EN
   localparam logic [SW:0]   C_DELAY = (SW + 1)'(DELAY);
`endif

   logic [WIDTH-1:0] mem [C_DEPTH];

   logic [SW-1:0]    wr_slot_q, wr_slot_d;
   logic [SW-1:0]    rd_slot_q, rd_slot_d;
   logic [SW:0]      count_q, count_d;
   logic             err_q, err_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q;

   logic             w_wr_ready;
   logic             w_rd_ready;
   logic             w_wr_we;
   logic             w_rd_accept;
   logic             w_commit;
   logic             w_release;
   logic             w_err_set;
   logic [SW+AW-1:0] w_wr_ptr;
   logic [SW+AW-1:0] w_rd_ptr;

   assign w_wr_ready  = (count_q != C_SLOTS);
   assign w_rd_ready  = (count_q != '0);
   assign w_wr_we     = wr_en & w_wr_ready;
   assign w_rd_accept = rd_en & w_rd_ready;
   // Slot index in the upper bits equals slot*2**AW + addr.
   assign w_wr_ptr    = {wr_slot_q, wr_addr};
   assign w_rd_ptr    = {rd_slot_q, rd_addr};

`ifdef DELAY_BLOCK_RING_FIXED_DELAY_EN
   // Count saturates at DELAY < SLOTS, so a shift always has a free slot.
   assign w_commit  = shift;
   assign w_release = shift & (count_q == C_DELAY);
   assign w_err_set = 1'b0;
`else
   assign w_commit  = wr_commit & w_wr_ready;
   assign w_release = rd_release & w_rd_ready;
   assign w_err_set = (wr_commit & ~w_wr_ready) | (rd_release & ~w_rd_ready);
`endif

   always_comb begin
      wr_slot_d  = wr_slot_q;
      rd_slot_d  = rd_slot_q;
      count_d    = count_q + (SW + 1)'(w_commit) - (SW + 1)'(w_release);
      err_d      = err_q | w_err_set;
      rd_valid_d = w_rd_accept;
      if (w_commit) begin
         wr_slot_d = (wr_slot_q == C_LAST) ? '0 : wr_slot_q + 1'b1;
      end
      if (w_release) begin
         rd_slot_d = (rd_slot_q == C_LAST) ? '0 : rd_slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_slot_q  <= '0;
         rd_slot_q  <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_slot_q  <= wr_slot_d;
         rd_slot_q  <= rd_slot_d;
         count_q    <= count_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // RAM array kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_we) begin
         mem[w_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (w_rd_accept) begin
         rd_data_q <= mem[w_rd_ptr];
      end
   end

   assign wr_ready = w_wr_ready;
   assign rd_ready = w_rd_ready;
   assign wr_slot  = wr_slot_q;
   assign rd_slot  = rd_slot_q;
   assign count    = count_q;
   assign err      = err_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_block_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_block_ring
// Purpose  : Self-checking bench for delay_block_ring (elastic build) with a
//            reference model and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_block_ring;

   localparam int WIDTH      = 16;
   localparam int BLOCK_SIZE = 8;
   localparam int SLOTS      = 4;
   localparam int AW         = 3;
   localparam int SW         = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_commit;
   logic             wr_ready;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_release;
   logic             rd_ready;
   logic [SW-1:0]    wr_slot;
   logic [SW-1:0]    rd_slot;
   logic [SW:0]      count;
   logic             err;

   always #5 clk = ~clk;

   delay_block_ring #(
      .WIDTH      (WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE),
      .SLOTS      (SLOTS)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_commit  (wr_commit),
      .wr_ready   (wr_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_release (rd_release),
      .rd_ready   (rd_ready),
      .wr_slot    (wr_slot),
      .rd_slot    (rd_slot),
      .count      (count),
      .err        (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [WIDTH-1:0] m_mem [SLOTS*BLOCK_SIZE];
   int               m_wr;
   int               m_rd;
   int               m_count;
   logic             m_err;
   logic             m_valid;
   logic [WIDTH-1:0] m_rd_data;
   logic [WIDTH-1:0] sb_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"},    32'(count),    32'(m_count));
      check({tag, "_wr_slot"},  32'(wr_slot),  32'(m_wr));
      check({tag, "_rd_slot"},  32'(rd_slot),  32'(m_rd));
      check({tag, "_err"},      32'(err),      32'(m_err));
      check({tag, "_wr_ready"}, 32'(wr_ready), 32'(m_count != SLOTS));
      check({tag, "_rd_ready"}, 32'(rd_ready), 32'(m_count != 0));
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'(m_valid));
      check({tag, "_rd_data"},  32'(rd_data),  32'(m_rd_data));
   endtask

   task automatic do_reset(input logic re);
      rst   = 1'b1;
      rd_en = re;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rd_en     = 1'b0;
      m_wr      = 0;
      m_rd      = 0;
      m_count   = 0;
      m_err     = 1'b0;
      m_valid   = 1'b0;
      m_rd_data = '0;
      sb_q.delete();
      check_state("rst");
   endtask

   // One clock with the given inputs; model updated from pre-edge state.
   task automatic cycle(input string tag, input logic we, input int wa, input logic [WIDTH-1:0] wd,
                        input logic wc, input logic re, input int ra, input logic rr);
      logic w_rdy, r_rdy;
      wr_en      = we;
      wr_addr    = AW'(wa);
      wr_data    = wd;
      wr_commit  = wc;
      rd_en      = re;
      rd_addr    = AW'(ra);
      rd_release = rr;
      @(posedge clk);
      w_rdy   = (m_count != SLOTS);
      r_rdy   = (m_count != 0);
      m_valid = re && r_rdy;
      if (m_valid) begin
         m_rd_data = m_mem[m_rd*BLOCK_SIZE + ra];
         sb_q.push_back(m_rd_data);
      end
      if (we && w_rdy) m_mem[m_wr*BLOCK_SIZE + wa] = wd;
      if ((wc && !w_rdy) || (rr && !r_rdy)) m_err = 1'b1;
      if (wc && w_rdy) begin
         m_wr = (m_wr + 1) % SLOTS;
         m_count++;
      end
      if (rr && r_rdy) begin
         m_rd = (m_rd + 1) % SLOTS;
         m_count--;
      end
      #1;
      wr_en      = 1'b0;
      wr_commit  = 1'b0;
      rd_en      = 1'b0;
      rd_release = 1'b0;
      if (rd_valid) begin
         if (sb_q.size() == 0) check({tag, "_sb_unexpected"}, 32'(rd_valid), 32'd0);
         else                  check({tag, "_sb_data"}, 32'(rd_data), 32'(sb_q.pop_front()));
      end else if (sb_q.size() != 0) begin
         check({tag, "_sb_missing"}, 32'(rd_valid), 32'd1);
         sb_q.delete();
      end
      check_state(tag);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;

      do_reset(1'b0);
      cycle("idle", 0, 0, 0, 0, 0, 0, 0);

      // Single block; last write shares the cycle with its commit.
      for (int i = 0; i < BLOCK_SIZE; i++)
         cycle("blk1_wr", 1, i, 16'(16'h1000 + i), i == BLOCK_SIZE - 1, 0, 0, 0);
      cycle("blk1_rd", 0, 0, 0, 0, 1, 3, 0);
      check("blk1_rd_data", 32'(rd_data), 32'h1003);

      // Fill all slots, then overflow write and commit.
      do_reset(1'b0);
      for (int s = 0; s < SLOTS; s++)
         for (int a = 0; a < BLOCK_SIZE; a++)
            cycle("fill", 1, a, 16'((s << 12) | (a << 4)), a == BLOCK_SIZE - 1, 0, 0, 0);
      check("full_count", 32'(count), 32'd4);
      cycle("drop_wr", 1, 0, 16'hFFFF, 0, 0, 0, 0);
      cycle("over_commit", 0, 0, 0, 1, 0, 0, 0);
      check("over_err", 32'(err), 32'd1);
      cycle("rd_s0a0", 0, 0, 0, 0, 1, 0, 0);
      check("dropped_wr_data", 32'(rd_data), 32'h0000);
      cycle("rd_rel", 0, 0, 0, 0, 1, 5, 1);
      check("rd_rel_data", 32'(rd_data), 32'h0050);
      for (int k = 0; k < SLOTS - 1; k++)
         cycle("drain", 0, 0, 0, 0, 1, k + 1, 1);

      // Simultaneous commit+release at count=2 through several wraps.
      do_reset(1'b0);
      cycle("c1", 0, 0, 0, 1, 0, 0, 0);
      cycle("c2", 0, 0, 0, 1, 0, 0, 0);
      for (int r = 0; r < 4 * SLOTS; r++)
         cycle("steady", 1, r % BLOCK_SIZE, 16'(16'h2000 + r), 1, 1, (r + 3) % BLOCK_SIZE, 1);
      check("steady_count", 32'(count), 32'd2);
      cycle("d1", 0, 0, 0, 0, 0, 0, 1);
      cycle("d2", 0, 0, 0, 0, 0, 0, 1);
      cycle("rel_empty", 0, 0, 0, 0, 0, 0, 1);
      check("rel_empty_err", 32'(err), 32'd1);
      cycle("rd_empty", 0, 0, 0, 0, 1, 2, 0);
      check("rd_empty_valid", 32'(rd_valid), 32'd0);

      // Reset mid-stream with a read in flight.
      do_reset(1'b0);
      for (int k = 0; k < 3; k++)
         cycle("pre_rst", 0, 0, 0, 1, 0, 0, 0);
      cycle("pre_rst_rd", 0, 0, 0, 0, 1, 1, 0);
      do_reset(1'b1);
      cycle("beef_wr", 1, 5, 16'hBEEF, 1, 0, 0, 0);
      cycle("beef_rd", 0, 0, 0, 0, 1, 5, 0);
      check("beef_data", 32'(rd_data), 32'hBEEF);

      // Randomised traffic against the model.
      for (int n = 0; n < 200; n++)
         cycle("rand", 1'($urandom_range(1)), int'($urandom_range(7)), 16'($urandom),
               $urandom_range(3) == 0, 1'($urandom_range(1)), int'($urandom_range(7)),
               $urandom_range(3) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
